btn_debouncer: RTL and testbench

//  Parametrised N-channel push-button/switch debouncer; successor to the fixed 5-bit sampler.
//  Per channel: 2-flop synchroniser, stable-time filter on a shared prescaled tick,

---
 rtl/btn_debouncer_pkg.sv | 21 ++
 rtl/btn_debouncer_if.sv | 30 +++
 rtl/btn_debounce_chan.sv | 109 ++++++++++
 rtl/btn_debouncer.sv | 70 +++++++
 tb/tb_btn_debouncer.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/btn_debouncer_pkg.sv
// Shared constants and helpers for the button input blocks.
// Holds default timing constants and a width helper used by the debouncer
// and its per-channel filter.
package btn_debouncer_pkg;

    localparam int DEF_N_CH          = 5;
    localparam int DEF_TICK_DIV      = 100000;
    localparam int DEF_STABLE_TICKS  = 4;
    localparam int DEF_REPEAT_DELAY  = 50;
    localparam int DEF_REPEAT_PERIOD = 10;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        clog2_min1 = (value <= 2) ? 1 : $clog2(value);
    endfunction

    function automatic int max_int(input int a, input int b);
        max_int = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debouncer_if.sv
// Button bundle between the board pins and the debouncer.
// master: the side that supplies raw buttons and consumes clean levels/pulses.
// slave : the debouncer itself.
interface btn_debouncer_if
    import btn_debouncer_pkg::*;
#(
    parameter int N_CH = DEF_N_CH
);
    logic [N_CH-1:0] button;
    logic [N_CH-1:0] button_out;
    logic [N_CH-1:0] button_rise;
    logic [N_CH-1:0] button_fall;
    logic [N_CH-1:0] button_repeat;

    modport master (
        output button,
        input  button_out,
        input  button_rise,
        input  button_fall,
        input  button_repeat
    );

    modport slave (
        input  button,
        output button_out,
        output button_rise,
        output button_fall,
        output button_repeat
    );
endinterface

// File: rtl/btn_debounce_chan.sv
// One debouncer channel: 2-flop synchroniser, stable-time filter driven by the
// shared sample tick, registered edge pulses and optional hold auto-repeat.
// Auto-repeat is built only when BTN_DEBOUNCE_AUTOREPEAT_EN is defined.
module btn_debounce_chan
    import btn_debouncer_pkg::*;
#(
    parameter int STABLE_TICKS  = DEF_STABLE_TICKS,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic button,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rpt
);
    localparam int STAB_W = clog2_min1(STABLE_TICKS + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);

    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("btn_debounce_chan: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic              s1_reg;
    logic              s2_reg;
    logic [STAB_W-1:0] stab_cnt_reg;
    logic              level_reg;
    logic              rise_reg;
    logic              fall_reg;
    logic              accept;

    // The synchronised input has differed for the full stable period on this tick.
    assign accept = (s2_reg != level_reg) && tick && (stab_cnt_reg == STAB_LAST);

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= button;
            s2_reg <= s1_reg;
        end
    end

    // Stable-time filter: any return to the current level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            stab_cnt_reg <= '0;
            level_reg    <= 1'b0;
            rise_reg     <= 1'b0;
            fall_reg     <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            if (s2_reg == level_reg) begin
                stab_cnt_reg <= '0;
            end else if (accept) begin
                level_reg    <= s2_reg;
                stab_cnt_reg <= '0;
                rise_reg     <= s2_reg;
                fall_reg     <= ~s2_reg;
            end else if (tick) begin
                stab_cnt_reg <= stab_cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam int REP_W = clog2_min1(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [REP_W-1:0] REP_DELAY_LOAD  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LOAD = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt_reg;
    logic             rpt_reg;

    // Hold auto-repeat: arm on press acceptance, count ticks while held, clear on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_reg <= '0;
            rpt_reg     <= 1'b0;
        end else begin
            rpt_reg <= 1'b0;
            if (accept) begin
                rep_cnt_reg <= s2_reg ? REP_DELAY_LOAD : '0;
            end else if (level_reg && tick) begin
                if (rep_cnt_reg == '0) begin
                    rpt_reg     <= 1'b1;
                    rep_cnt_reg <= REP_PERIOD_LOAD;
                end else begin
                    rep_cnt_reg <= rep_cnt_reg - 1'b1;
                end
            end
        end
    end

    assign rpt = rpt_reg;
`else
    assign rpt = 1'b0;
`endif

endmodule

// File: rtl/btn_debouncer.sv
// N-channel push-button/switch debouncer.
// A shared prescaler produces the sample tick; each channel filters independently.
// Optional feature macro: BTN_DEBOUNCE_AUTOREPEAT_EN enables hold auto-repeat
// pulses on button_repeat; without it button_repeat is held at zero.
module btn_debouncer
    import btn_debouncer_pkg::*;
#(
    parameter int N_CH          = DEF_N_CH,
    parameter int TICK_DIV      = DEF_TICK_DIV,
    parameter int STABLE_TICKS  = DEF_STABLE_TICKS,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic            clk,
    input  logic            rst,
    btn_debouncer_if.slave  bus
);
    localparam int DIV_W = clog2_min1(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    if (STABLE_TICKS < 1 || TICK_DIV < 1 || REPEAT_PERIOD < 1 || N_CH < 1) begin : g_bad_param
        $error("btn_debouncer: N_CH, TICK_DIV, STABLE_TICKS and REPEAT_PERIOD must be >= 1");
    end

    logic [DIV_W-1:0] div_cnt_reg;
    logic             tick;
    logic [N_CH-1:0]  level_vec;
    logic [N_CH-1:0]  rise_vec;
    logic [N_CH-1:0]  fall_vec;
    logic [N_CH-1:0]  rpt_vec;

    // Shared prescaler: tick is high for the single cycle the count sits at its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg <= '0;
        end else if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    assign tick = (div_cnt_reg == DIV_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_chan
            btn_debounce_chan #(
                .STABLE_TICKS  (STABLE_TICKS),
                .REPEAT_DELAY  (REPEAT_DELAY),
                .REPEAT_PERIOD (REPEAT_PERIOD)
            ) u_chan (
                .clk    (clk),
                .rst    (rst),
                .tick   (tick),
                .button (bus.button[gi]),
                .level  (level_vec[gi]),
                .rise   (rise_vec[gi]),
                .fall   (fall_vec[gi]),
                .rpt    (rpt_vec[gi])
            );
        end
    endgenerate

    assign bus.button_out    = level_vec;
    assign bus.button_rise   = rise_vec;
    assign bus.button_fall   = fall_vec;
    assign bus.button_repeat = rpt_vec;

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer.
// dut_a: TICK_DIV=1, STABLE_TICKS=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
// dut_b: same but TICK_DIV=4, used for the prescaled latency window.
module tb_btn_debouncer;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    btn_debouncer_if #(.N_CH(5)) bus_a ();
    btn_debouncer_if #(.N_CH(5)) bus_b ();

    btn_debouncer #(
        .N_CH(5), .TICK_DIV(1), .STABLE_TICKS(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a.slave)
    );

    btn_debouncer #(
        .N_CH(5), .TICK_DIV(4), .STABLE_TICKS(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        $display("[%0t] %s obs=%b exp=%b", $time, tag, obs, exp);
    endtask

    initial begin
        logic [4:0] e;
        int  lat;
        bit  found;

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.button = 5'b0;
        bus_b.button = 5'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_a",  bus_a.button_out,    5'b0);
        chk("rst_rise_a", bus_a.button_rise,   5'b0);
        chk("rst_fall_a", bus_a.button_fall,   5'b0);
        chk("rst_rpt_a",  bus_a.button_repeat, 5'b0);
        chk("rst_out_b",  bus_b.button_out,    5'b0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        chk("post_rst_rise", bus_a.button_rise, 5'b0);
        chk("post_rst_fall", bus_a.button_fall, 5'b0);

        // 1: clean press on ch0
        bus_a.button[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("press_out k=%0d", k),  bus_a.button_out,  (k >= 6) ? 5'b00001 : 5'b0);
            chk($sformatf("press_rise k=%0d", k), bus_a.button_rise, (k == 6) ? 5'b00001 : 5'b0);
            chk($sformatf("press_fall k=%0d", k), bus_a.button_fall, 5'b0);
        end

        // 3: release ch0
        bus_a.button[0] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("rel_out k=%0d", k),  bus_a.button_out,  (k < 6) ? 5'b00001 : 5'b0);
            chk($sformatf("rel_fall k=%0d", k), bus_a.button_fall, (k == 6) ? 5'b00001 : 5'b0);
            chk($sformatf("rel_rise k=%0d", k), bus_a.button_rise, 5'b0);
        end

        // 2: bounce on ch2, toggling every 2 clk for 20 clk
        for (int i = 0; i < 10; i++) begin
            bus_a.button[2] = ~bus_a.button[2];
            repeat (2) begin
                @(negedge clk);
                chk($sformatf("bounce_out i=%0d", i),   bus_a.button_out,  5'b0);
                chk($sformatf("bounce_pulse i=%0d", i), bus_a.button_rise | bus_a.button_fall, 5'b0);
            end
        end
        bus_a.button[2] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("settle_out k=%0d", k),  bus_a.button_out,  (k >= 6) ? 5'b00100 : 5'b0);
            chk($sformatf("settle_rise k=%0d", k), bus_a.button_rise, (k == 6) ? 5'b00100 : 5'b0);
        end
        bus_a.button[2] = 1'b0;
        repeat (7) @(negedge clk);
        chk("settle_release", bus_a.button_out, 5'b0);

        // 4: simultaneous press on ch1 and ch3
        bus_a.button = 5'b01010;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("simul_out k=%0d", k),  bus_a.button_out,  (k >= 6) ? 5'b01010 : 5'b0);
            chk($sformatf("simul_rise k=%0d", k), bus_a.button_rise, (k == 6) ? 5'b01010 : 5'b0);
        end
        bus_a.button = 5'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("simul_fall k=%0d", k), bus_a.button_fall, (k == 6) ? 5'b01010 : 5'b0);
        end
        chk("simul_released", bus_a.button_out, 5'b0);

        // 5: reset while ch0 count is at 2
        bus_a.button[0] = 1'b1;
        repeat (4) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        chk("midrst_out",  bus_a.button_out,  5'b0);
        chk("midrst_rise", bus_a.button_rise, 5'b0);
        rst_a = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("midrst_out k=%0d", k),  bus_a.button_out,  (k >= 6) ? 5'b00001 : 5'b0);
            chk($sformatf("midrst_rise k=%0d", k), bus_a.button_rise, (k == 6) ? 5'b00001 : 5'b0);
        end
        bus_a.button[0] = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrst_release", bus_a.button_out, 5'b0);

        // 6: hold ch4 for auto-repeat, then release
        bus_a.button[4] = 1'b1;
        repeat (6) @(negedge clk);
        chk("hold_out_rise", bus_a.button_out,    5'b10000);
        chk("hold_rise",     bus_a.button_rise,   5'b10000);
        chk("hold_rpt_rise", bus_a.button_repeat, 5'b0);
        for (int off = 1; off <= 40; off++) begin
            @(negedge clk);
            e = (REP_ON && off >= 10 && off <= 25 && ((off - 10) % 5) == 0) ? 5'b10000 : 5'b0;
            chk($sformatf("hold_rpt off=%0d", off), bus_a.button_repeat, e);
            chk($sformatf("hold_out off=%0d", off), bus_a.button_out, (off < 27) ? 5'b10000 : 5'b0);
            chk($sformatf("hold_fall off=%0d", off), bus_a.button_fall, (off == 27) ? 5'b10000 : 5'b0);
            if (off == 21) bus_a.button[4] = 1'b0;
        end

        // 5b: prescaled latency window on dut_b
        bus_b.button[0] = 1'b1;
        lat   = 0;
        found = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!found && bus_b.button_out[0]) begin
                found = 1'b1;
                lat   = k;
                chk("b_rise_at_edge", bus_b.button_rise, 5'b00001);
            end
        end
        vectors++;
        assert (found && lat >= 15 && lat <= 18) else begin
            miscompares++;
            $error("FAIL b_latency observed=%0d required=15..18", lat);
        end
        $display("[%0t] b_latency obs=%0d exp=15..18", $time, lat);
        chk("b_out_final",  bus_b.button_out,  5'b00001);
        chk("b_rise_final", bus_b.button_rise, 5'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
